// File: rtl/led_disp_pkg.sv
// Shared types and helpers for the LED binary display.
package led_disp_pkg;

    // Display mode encoding seen on the mode input.
    typedef enum logic [1:0] {
        MODE_DIRECT  = 2'd0,
        MODE_BLINK   = 2'd1,
        MODE_CHANGED = 2'd2,
        MODE_OFF     = 2'd3
    } led_mode_e;

    // Bits needed to count 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/led_pwm_gen.sv
// Free-running PWM counter and brightness compare.
// pwm_on is high for `brightness` cycles of every 2**PWM_BITS, and
// permanently high at full brightness so there is no one-cycle gap.
module led_pwm_gen
    import led_disp_pkg::*;
#(
    parameter int unsigned PWM_BITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PWM_BITS-1:0] brightness,
    output logic                pwm_on
);

    logic [PWM_BITS-1:0] r_pwm_cnt;

    // Counter wraps naturally from all-ones back to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
        end
    end

    // Duty compare, with the all-ones code forced fully on.
    assign pwm_on = (r_pwm_cnt < brightness) || (&brightness);

endmodule

// File: rtl/led_bin_display_pwm.sv
// Binary LED display with capture strobe, blink modes and PWM dimming.
// Optional build macro LED_ACTIVE_LOW_EN inverts the leds output (reset
// value then all-ones); blink_phase is never inverted.
module led_bin_display_pwm
    import led_disp_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned BLINK_DIV = 25_000_000,
    parameter int unsigned PWM_BITS  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WIDTH-1:0]    bin_num,
    input  logic                load,
    input  logic [1:0]          mode,
    input  logic [PWM_BITS-1:0] brightness,
    output logic [WIDTH-1:0]    leds,
    output logic                blink_phase
);

    localparam int unsigned BW = cnt_width(BLINK_DIV);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

`ifdef LED_ACTIVE_LOW_EN
    localparam logic [WIDTH-1:0] LEDS_RST = '1;
`else
    localparam logic [WIDTH-1:0] LEDS_RST = '0;
`endif

    logic [WIDTH-1:0] r_value;
    logic [WIDTH-1:0] r_prev;
    logic [BW-1:0]    r_blink_cnt;
    logic             r_blink_phase;
    logic [WIDTH-1:0] r_leds;

    logic             w_pwm_on;
    logic [WIDTH-1:0] w_chg;
    logic [WIDTH-1:0] w_steady;
    logic [WIDTH-1:0] w_pattern;
    logic [WIDTH-1:0] w_leds_d;

    // Capture: the previous value is kept so changed bits can be shown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= '0;
            r_prev  <= '0;
        end else if (load) begin
            r_prev  <= r_value;
            r_value <= bin_num;
        end
    end

    // Free-running blink divider; phase flips on each wrap, starting lit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b1;
        end else if (r_blink_cnt == BLINK_LAST) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
        end else begin
            r_blink_cnt   <= r_blink_cnt + BW'(1);
        end
    end

    led_pwm_gen #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm (
        .clk        (clk),
        .rst_n      (rst_n),
        .brightness (brightness),
        .pwm_on     (w_pwm_on)
    );

    assign w_chg    = r_value ^ r_prev;
    assign w_steady = r_value & ~w_chg;

    // Pattern select by display mode.
    always_comb begin
        w_pattern = '0;
        unique case (led_mode_e'(mode))
            MODE_DIRECT:  w_pattern = r_value;
            MODE_BLINK:   w_pattern = r_blink_phase ? r_value : '0;
            MODE_CHANGED: w_pattern = w_steady | (r_blink_phase ? w_chg : '0);
            MODE_OFF:     w_pattern = '0;
        endcase
    end

`ifdef LED_ACTIVE_LOW_EN
    assign w_leds_d = ~(w_pattern & {WIDTH{w_pwm_on}});
`else
    assign w_leds_d = w_pattern & {WIDTH{w_pwm_on}};
`endif

    // Output register: gated pattern, one stage after capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_leds <= LEDS_RST;
        end else begin
            r_leds <= w_leds_d;
        end
    end

    assign leds        = r_leds;
    assign blink_phase = r_blink_phase;

endmodule

// File: tb/tb_led_bin_display_pwm.sv
// Self-checking bench for led_bin_display_pwm (WIDTH=4, BLINK_DIV=4,
// PWM_BITS=2). Honours LED_ACTIVE_LOW_EN when the build defines it.
module tb_led_bin_display_pwm;

    localparam int unsigned WIDTH     = 4;
    localparam int unsigned BLINK_DIV = 4;
    localparam int unsigned PWM_BITS  = 2;
    localparam int unsigned PWM_PER   = 1 << PWM_BITS;

`ifdef LED_ACTIVE_LOW_EN
    localparam logic [WIDTH-1:0] POL = '1;
`else
    localparam logic [WIDTH-1:0] POL = '0;
`endif

    logic                clk;
    logic                rst_n;
    logic [WIDTH-1:0]    bin_num;
    logic                load;
    logic [1:0]          mode;
    logic [PWM_BITS-1:0] brightness;
    logic [WIDTH-1:0]    leds;
    logic                blink_phase;

    led_bin_display_pwm #(
        .WIDTH     (WIDTH),
        .BLINK_DIV (BLINK_DIV),
        .PWM_BITS  (PWM_BITS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bin_num     (bin_num),
        .load        (load),
        .mode        (mode),
        .brightness  (brightness),
        .leds        (leds),
        .blink_phase (blink_phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: captured values and edges since reset release.
    logic [WIDTH-1:0] m_val;
    logic [WIDTH-1:0] m_prev;
    int unsigned      m_k;
    logic [WIDTH-1:0] exp_leds;
    logic             exp_phase;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic phase_at(input int unsigned k);
        return ((k / BLINK_DIV) % 2) == 0;
    endfunction

    task automatic model_reset();
        m_val     = '0;
        m_prev    = '0;
        m_k       = 0;
        exp_leds  = POL;
        exp_phase = 1'b1;
    endtask

    // One clock edge of the specified behaviour, from pre-edge state.
    task automatic model_edge(input logic ld, input logic [WIDTH-1:0] bn,
                              input logic [1:0] md, input logic [PWM_BITS-1:0] br);
        logic             ph;
        logic             on;
        logic [WIDTH-1:0] chg;
        logic [WIDTH-1:0] pat;
        ph  = phase_at(m_k);
        on  = (int'(br) == PWM_PER - 1) || ((m_k % PWM_PER) < br);
        chg = m_val ^ m_prev;
        case (md)
            2'd0:    pat = m_val;
            2'd1:    pat = ph ? m_val : '0;
            2'd2:    pat = (m_val & ~chg) | (ph ? chg : '0);
            default: pat = '0;
        endcase
        exp_leds = (on ? pat : '0) ^ POL;
        if (ld) begin
            m_prev = m_val;
            m_val  = bn;
        end
        m_k++;
        exp_phase = phase_at(m_k);
    endtask

    task automatic step(input logic ld, input logic [WIDTH-1:0] bn,
                        input logic [1:0] md, input logic [PWM_BITS-1:0] br);
        load       = ld;
        bin_num    = bn;
        mode       = md;
        brightness = br;
        @(posedge clk);
        model_edge(ld, bn, md, br);
        #1;
        check_val("leds", 32'(leds), 32'(exp_leds));
        check_val("blink_phase", 32'(blink_phase), 32'(exp_phase));
    endtask

    // Async reset asserted between edges, released between edges.
    task automatic mid_reset();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_val("async_rst_leds", 32'(leds), 32'(POL));
        check_val("async_rst_phase", 32'(blink_phase), 32'd1);
        @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    int lit_cnt;

    initial begin
        rst_n      = 1'b0;
        load       = 1'b0;
        bin_num    = '0;
        mode       = 2'd0;
        brightness = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_leds", 32'(leds), 32'(POL));
        check_val("reset_phase", 32'(blink_phase), 32'd1);
        #2 rst_n = 1'b1;

        // Direct display with one-cycle load.
        step(1'b1, 4'b1010, 2'd0, 2'd3);
        check_val("direct_first_edge", 32'(leds), 32'(4'b0000 ^ POL));
        step(1'b0, 4'b0000, 2'd0, 2'd3);
        check_val("direct_second_edge", 32'(leds), 32'(4'b1010 ^ POL));
        repeat (5) step(1'b0, 4'b0000, 2'd0, 2'd3);
        check_val("direct_steady", 32'(leds), 32'(4'b1010 ^ POL));

        // Blink mode.
        step(1'b1, 4'b0110, 2'd1, 2'd3);
        repeat (16) step(1'b0, 4'b0000, 2'd1, 2'd3);

        // Changed-bits mode, including a 1->0 transition.
        step(1'b1, 4'b1100, 2'd2, 2'd3);
        step(1'b1, 4'b1010, 2'd2, 2'd3);
        repeat (12) step(1'b0, 4'b0000, 2'd2, 2'd3);

        // Reload of an identical value: nothing flashes.
        step(1'b1, 4'b1010, 2'd2, 2'd3);
        repeat (9) step(1'b0, 4'b0000, 2'd2, 2'd3);
        check_val("same_value_no_flash", 32'(leds), 32'(4'b1010 ^ POL));

        // PWM duty 1/4, then fully dark.
        step(1'b1, 4'b1111, 2'd0, 2'd1);
        step(1'b0, 4'b0000, 2'd0, 2'd1);
        lit_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 4'b0000, 2'd0, 2'd1);
            if ((leds ^ POL) == 4'b1111) lit_cnt++;
        end
        check_val("pwm_quarter_duty", 32'(lit_cnt), 32'd2);
        lit_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 4'b0000, 2'd0, 2'd0);
            if ((leds ^ POL) != 4'b0000) lit_cnt++;
        end
        check_val("pwm_dark", 32'(lit_cnt), 32'd0);

        // Off mode.
        repeat (3) step(1'b0, 4'b0000, 2'd3, 2'd3);
        check_val("mode_off", 32'(leds), 32'(POL));

        // Reset mid-blink, then confirm the captured value was cleared.
        repeat (5) step(1'b0, 4'b0000, 2'd1, 2'd3);
        mid_reset();
        repeat (3) step(1'b0, 4'b0000, 2'd0, 2'd3);
        check_val("value_cleared", 32'(leds), 32'(POL));

        // Randomised traffic against the model, with one extra reset.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) == 0), WIDTH'($urandom),
                 2'($urandom), PWM_BITS'($urandom));
            if (i == 200) mid_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
